// File: rtl/gate_pkg.sv
// Shared opcodes and FSM encoding for the gate-unit arbiter slice.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/gate_unit_arbiter_logic_unit.sv
// Combinational WIDTH-bit gate unit; codes 6/7 return zero with err set.
module logic_unit
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit among N_REQ requesters;
// one operation in flight, registered grant and response.
module gate_unit_arbiter
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [3*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] a,
  input  logic [WIDTH*N_REQ-1:0] b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   busy
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr, cur_id;
  logic [2:0]        op_r;
  logic [WIDTH-1:0]  a_r, b_r;
  logic [WIDTH-1:0]  lu_y;
  logic              lu_err;

  logic              win_found;
  logic [ID_W-1:0]   win_id, idx;
  logic [ID_W:0]     idx_w;
  logic [2:0]        win_op;
  logic [WIDTH-1:0]  win_a, win_b;

  // Search upward from ptr with wrap; an extra bit keeps the sum from overflowing.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx_w     = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_w = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx_w >= (ID_W+1)'(N_REQ)) idx_w = idx_w - (ID_W+1)'(N_REQ);
      idx = idx_w[ID_W-1:0];
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_op = op[3*i +: 3];
        win_a  = a[WIDTH*i +: WIDTH];
        win_b  = b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign busy = (state_q != IDLE);

  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .a   (a_r),
    .b   (b_r),
    .op  (op_r),
    .y   (lu_y),
    .err (lu_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      ptr       <= '0;
      cur_id    <= '0;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      gnt <= '0;
      case (state_q)
        IDLE: if (win_found) begin
          gnt    <= N_REQ'(1) << win_id;
          cur_id <= win_id;
          op_r   <= win_op;
          a_r    <= win_a;
          b_r    <= win_b;
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_data  <= lu_y;
          rsp_err   <= lu_err;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr       <= (cur_id == ID_W'(N_REQ-1)) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter (WIDTH=8, N_REQ=4) with hand-computed expectations.
module tb_gate_unit_arbiter;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [3*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] a, b;
  logic [N_REQ-1:0]       gnt;
  logic                   rsp_valid, rsp_ready, rsp_err, busy;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  gate_unit_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb);
    op[3*i +: 3]     = o;
    a[WIDTH*i +: 8]  = va;
    b[WIDTH*i +: 8]  = vb;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_gnt"},   32'(gnt), 32'h0);
    check({tag, "_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  logic [7:0] sweep_exp [8] = '{8'h88, 8'hEE, 8'h33, 8'h77, 8'h11, 8'h66, 8'h00, 8'h00};

  initial begin
    rst = 1'b1; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b1;
    step(); step();
    check_idle_outs("reset");
    check("reset_id",   32'(rsp_id), 32'h0);
    check("reset_data", 32'(rsp_data), 32'h0);
    check("reset_err",  32'(rsp_err), 32'h0);
    rst = 1'b0;
    repeat (3) begin
      step();
      check("idle_busy", 32'(busy), 32'h0);
    end

    // asynchronous reset while a grant is showing
    req = 4'b1111;
    step();
    check("pre_async_gnt", 32'(gnt), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_idle_outs("async_rst");
    req = '0;
    step();
    rst = 1'b0;
    step();

    // single request, AND
    set_slot(0, 3'd0, 8'hF0, 8'h3C);
    req = 4'b0001;
    step();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_noval", 32'(rsp_valid), 32'h0);
    req = '0;
    step();
    check("single_gnt_off", 32'(gnt), 32'h0);
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_id",    32'(rsp_id), 32'h0);
    check("single_data",  32'(rsp_data), 32'h30);
    check("single_err",   32'(rsp_err), 32'h0);
    step();
    check_idle_outs("single_done");

    // opcode sweep through requester 2
    for (int k = 0; k < 8; k++) begin
      set_slot(2, 3'(k), 8'hCC, 8'hAA);
      req = 4'b0100;
      step();
      check("sweep_gnt", 32'(gnt), 32'h4);
      req = '0;
      step();
      check("sweep_valid", 32'(rsp_valid), 32'h1);
      check("sweep_id",    32'(rsp_id), 32'h2);
      check("sweep_data",  32'(rsp_data), 32'(sweep_exp[k]));
      check("sweep_err",   32'(rsp_err), (k >= 6) ? 32'h1 : 32'h0);
      step();
      check("sweep_done", 32'(rsp_valid), 32'h0);
    end

    // fairness from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int i = 0; i < N_REQ; i++) set_slot(i, 3'd0, 8'hFF, 8'((i + 1) * 8'h11));
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      step();
      check("fair_gnt", 32'(gnt), 32'(4'b0001 << (t % 4)));
      step();
      check("fair_gap1", 32'(gnt), 32'h0);
      check("fair_id",   32'(rsp_id), 32'(t % 4));
      check("fair_data", 32'(rsp_data), 32'(((t % 4) + 1) * 8'h11));
      step();
      check("fair_gap2", 32'(gnt), 32'h0);
      check("fair_hs",   32'(rsp_valid), 32'h0);
    end
    req = '0;

    // backpressure on requester 3, req held high
    set_slot(3, 3'd5, 8'h3C, 8'h0F);
    req = 4'b1000;
    step();
    check("bp_gnt", 32'(gnt), 32'h8);
    rsp_ready = 1'b0;
    step();
    check("bp_valid", 32'(rsp_valid), 32'h1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_valid", 32'(rsp_valid), 32'h1);
      check("bp_hold_id",    32'(rsp_id), 32'h3);
      check("bp_hold_data",  32'(rsp_data), 32'h33);
      check("bp_hold_gnt",   32'(gnt), 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_hs_valid", 32'(rsp_valid), 32'h0);
    check("bp_hs_gnt",   32'(gnt), 32'h0);
    step();
    check("bp_regnt", 32'(gnt), 32'h8);
    req = '0;
    step(); step();
    check("bp_done", 32'(busy), 32'h0);

    // move pointer to 2, then reset during EXEC
    set_slot(1, 3'd1, 8'h01, 8'h02);
    req = 4'b0010;
    step();
    check("ptr_gnt", 32'(gnt), 32'h2);
    req = '0;
    step(); step();
    req = 4'b0100;
    step();
    check("mid_gnt", 32'(gnt), 32'h4);
    req = '0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy), 32'h0);
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("mid_no_rsp", 32'(rsp_valid), 32'h0);
    end
    req = 4'b0110;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    check("post_rst_id",   32'(rsp_id), 32'h1);
    check("post_rst_data", 32'(rsp_data), 32'h03);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
